// File: rtl/ddr_req_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_req_arb_pkg
// Brief    : Shared widths, owner ids and sequencer state encoding for ddr_req_arb.
// Revision : 1.0
// ============================================================================
package ddr_req_arb_pkg;

    localparam int DDR_ADDR_W = 27;
    localparam int DDR_DATA_W = 64;
    localparam int DDR_BE_W   = 8;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EARLY = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ddr_req_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter; on update the served port becomes "last".
// Revision : 1.0
// ============================================================================
module rr_arb2
    import ddr_req_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last,
    output logic [1:0] gnt
);

    logic r_last;

    // Reset value B makes A the favoured port for the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= OWNER_B;
        end else if (update) begin
            r_last <= last;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req[OWNER_A] && (!req[OWNER_B] || r_last == OWNER_B)) begin
            gnt[OWNER_A] = 1'b1;
        end else if (req[OWNER_B]) begin
            gnt[OWNER_B] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : ddr_req_arb
// Brief    : Two-port burst arbiter/sequencer for the ddr_top PCI-side port.
//            Optional stall timeout enabled by DDR_REQ_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module ddr_req_arb
    import ddr_req_arb_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [DDR_ADDR_W-1:0] a_addr,
    input  logic [LEN_W-1:0]      a_len,
    input  logic [DDR_DATA_W-1:0] a_wdata,
    input  logic [DDR_BE_W-1:0]   a_be,
    input  logic                  a_wvalid,
    output logic                  a_wready,
    output logic [DDR_DATA_W-1:0] a_rdata,
    output logic                  a_rvalid,
    output logic                  a_gnt,
    output logic                  a_done,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [DDR_ADDR_W-1:0] b_addr,
    input  logic [LEN_W-1:0]      b_len,
    input  logic [DDR_DATA_W-1:0] b_wdata,
    input  logic [DDR_BE_W-1:0]   b_be,
    input  logic                  b_wvalid,
    output logic                  b_wready,
    output logic [DDR_DATA_W-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  b_gnt,
    output logic                  b_done,
    output logic [DDR_ADDR_W-1:0] ddr_addr,
    output logic [DDR_DATA_W-1:0] ddr_wdata,
    output logic [DDR_BE_W-1:0]   ddr_cbe,
    output logic                  ddr_wvalid,
    output logic                  ddr_write,
    output logic                  ddr_hit_early,
    output logic                  ddr_hit,
    output logic                  ddr_done,
    input  logic                  ddr_ready,
    input  logic                  ddr_term,
    input  logic                  ddr_wait,
    input  logic                  ddr_not_ready,
    input  logic [DDR_DATA_W-1:0] ddr_rdata,
    input  logic                  ddr_rvalid,
    output logic                  err
);

    state_t                r_state;
    logic                  r_owner;
    logic                  r_wr;
    logic [DDR_ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_a_gnt;
    logic                  r_b_gnt;
    logic                  r_hit_early;
    logic                  r_hit;
    logic                  r_done;
    logic                  r_a_done;
    logic                  r_b_done;

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_rr_update;
    logic                  w_xfer;
    logic                  w_own_wvalid;
    logic [DDR_DATA_W-1:0] w_own_wdata;
    logic [DDR_BE_W-1:0]   w_own_be;
    logic                  w_wready;
    logic                  w_wbeat;
    logic                  w_rbeat;
    logic                  w_beat;
    logic                  w_timeout;
    logic                  w_end;

    // New grants only from IDLE and only while the DDR side is ready.
    assign w_req       = (r_state == IDLE && !ddr_not_ready) ? {b_req, a_req} : 2'b00;
    assign w_rr_update = (r_state == DONE);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (w_req),
        .update (w_rr_update),
        .last   (r_owner),
        .gnt    (w_gnt)
    );

    assign w_xfer       = (r_state == XFER);
    assign w_own_wvalid = (r_owner == OWNER_B) ? b_wvalid : a_wvalid;
    assign w_own_wdata  = (r_owner == OWNER_B) ? b_wdata  : a_wdata;
    assign w_own_be     = (r_owner == OWNER_B) ? b_be     : a_be;

    assign w_wready = w_xfer & r_wr & ddr_ready & ~ddr_wait;
    assign w_wbeat  = w_wready & w_own_wvalid;
    assign w_rbeat  = w_xfer & ~r_wr & ddr_rvalid;
    assign w_beat   = w_wbeat | w_rbeat;
    assign w_end    = w_xfer & ((w_beat && r_cnt == '0) | ddr_term | w_timeout);

    assign a_wready   = w_wready & (r_owner == OWNER_A);
    assign b_wready   = w_wready & (r_owner == OWNER_B);
    assign ddr_wvalid = w_wbeat;
    assign ddr_wdata  = w_wbeat ? w_own_wdata : '0;
    assign ddr_cbe    = w_wbeat ? ~w_own_be   : '0;

    assign a_rvalid = w_rbeat & (r_owner == OWNER_A);
    assign b_rvalid = w_rbeat & (r_owner == OWNER_B);
    assign a_rdata  = a_rvalid ? ddr_rdata : '0;
    assign b_rdata  = b_rvalid ? ddr_rdata : '0;

`ifdef DDR_REQ_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] r_stall;
    logic               r_err;

    // Counts consecutive beat-less XFER cycles; the TIMEOUT-th one ends the burst.
    assign w_timeout = w_xfer & ~w_beat & (r_stall == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (!w_xfer || w_beat) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + STALL_W'(1);
            end
        end
    end

    assign err = r_err;
`else
    localparam int c_unused_timeout = TIMEOUT;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWNER_A;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_hit_early <= 1'b0;
            r_hit       <= 1'b0;
            r_done      <= 1'b0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
        end else begin
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_hit_early <= 1'b0;
            r_done      <= 1'b0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_owner     <= w_gnt[OWNER_B] ? OWNER_B : OWNER_A;
                        r_wr        <= w_gnt[OWNER_B] ? b_wr   : a_wr;
                        r_addr      <= w_gnt[OWNER_B] ? b_addr : a_addr;
                        r_cnt       <= w_gnt[OWNER_B] ? b_len  : a_len;
                        r_a_gnt     <= w_gnt[OWNER_A];
                        r_b_gnt     <= w_gnt[OWNER_B];
                        r_hit_early <= 1'b1;
                        r_state     <= EARLY;
                    end
                end
                EARLY: begin
                    r_hit   <= 1'b1;
                    r_state <= XFER;
                end
                XFER: begin
                    if (w_end) begin
                        r_hit    <= 1'b0;
                        r_done   <= 1'b1;
                        r_a_done <= (r_owner == OWNER_A);
                        r_b_done <= (r_owner == OWNER_B);
                        r_state  <= DONE;
                    end else if (w_beat) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                DONE: begin
                    r_wr    <= 1'b0;
                    r_addr  <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a_gnt         = r_a_gnt;
    assign b_gnt         = r_b_gnt;
    assign a_done        = r_a_done;
    assign b_done        = r_b_done;
    assign ddr_addr      = r_addr;
    assign ddr_write     = r_wr;
    assign ddr_hit_early = r_hit_early;
    assign ddr_hit       = r_hit;
    assign ddr_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ddr_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_req_arb
// Brief    : Randomized burst-level self-check of ddr_req_arb.
// Revision : 1.0
// ============================================================================
module tb_ddr_req_arb;

    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_wr, a_wvalid, a_wready, a_rvalid, a_gnt, a_done;
    logic [26:0] a_addr;
    logic [3:0]  a_len;
    logic [63:0] a_wdata, a_rdata;
    logic [7:0]  a_be;
    logic        b_req, b_wr, b_wvalid, b_wready, b_rvalid, b_gnt, b_done;
    logic [26:0] b_addr;
    logic [3:0]  b_len;
    logic [63:0] b_wdata, b_rdata;
    logic [7:0]  b_be;
    logic [26:0] ddr_addr;
    logic [63:0] ddr_wdata, ddr_rdata;
    logic [7:0]  ddr_cbe;
    logic        ddr_wvalid, ddr_write, ddr_hit_early, ddr_hit, ddr_done;
    logic        ddr_ready, ddr_term, ddr_wait, ddr_not_ready, ddr_rvalid, err;

    ddr_req_arb #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_len(a_len), .a_wdata(a_wdata),
        .a_be(a_be), .a_wvalid(a_wvalid), .a_wready(a_wready), .a_rdata(a_rdata),
        .a_rvalid(a_rvalid), .a_gnt(a_gnt), .a_done(a_done),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
        .b_be(b_be), .b_wvalid(b_wvalid), .b_wready(b_wready), .b_rdata(b_rdata),
        .b_rvalid(b_rvalid), .b_gnt(b_gnt), .b_done(b_done),
        .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata), .ddr_cbe(ddr_cbe), .ddr_wvalid(ddr_wvalid),
        .ddr_write(ddr_write), .ddr_hit_early(ddr_hit_early), .ddr_hit(ddr_hit),
        .ddr_done(ddr_done), .ddr_ready(ddr_ready), .ddr_term(ddr_term), .ddr_wait(ddr_wait),
        .ddr_not_ready(ddr_not_ready), .ddr_rdata(ddr_rdata), .ddr_rvalid(ddr_rvalid),
        .err(err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_last   = 1;     // port served last; 1 (B) means A is favoured
    logic        cfg_wr[2];
    logic [26:0] cfg_addr[2];
    logic [3:0]  cfg_len[2];
    logic [63:0] m_wdata[16];
    logic [7:0]  m_be[16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_req = 0; a_wvalid = 0; a_wdata = '0; a_be = '0;
        b_req = 0; b_wvalid = 0; b_wdata = '0; b_be = '0;
        ddr_ready = 0; ddr_term = 0; ddr_wait = 0; ddr_not_ready = 0;
        ddr_rdata = '0; ddr_rvalid = 0;
    endtask

    task automatic randomize_cfg();
        for (int p = 0; p < 2; p++) begin
            cfg_wr[p]   = 1'($urandom_range(0, 1));
            cfg_addr[p] = 27'($urandom);
            cfg_len[p]  = 4'($urandom_range(0, 15));
        end
        for (int i = 0; i < 16; i++) begin
            m_wdata[i] = {$urandom, $urandom};
            m_be[i]    = 8'($urandom);
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_ctl"}, {a_gnt, b_gnt, a_done, b_done, a_wready, b_wready, a_rvalid, b_rvalid,
                            ddr_wvalid, ddr_write, ddr_hit_early, ddr_hit, ddr_done, err}, 64'd0);
        chk({tag, "_addr"}, ddr_addr, 64'd0);
        chk({tag, "_wdata"}, ddr_wdata, 64'd0);
        chk({tag, "_cbe"}, ddr_cbe, 64'd0);
        chk({tag, "_rdata"}, a_rdata | b_rdata, 64'd0);
    endtask

    // Request, then check the registered grant and the EARLY cycle.
    task automatic grant_phase(input logic [1:0] reqs, output int owner);
        owner = (reqs == 2'b11) ? (1 - m_last) : (reqs[1] ? 1 : 0);
        @(negedge clk);
        a_wr = cfg_wr[0]; a_addr = cfg_addr[0]; a_len = cfg_len[0];
        b_wr = cfg_wr[1]; b_addr = cfg_addr[1]; b_len = cfg_len[1];
        a_req = reqs[0]; b_req = reqs[1];
        #1;
        chk("gnt_pre", {a_gnt, b_gnt}, 64'd0);
        @(negedge clk);
        a_req = 0; b_req = 0;
        a_addr = 27'($urandom); b_addr = 27'($urandom); a_wr = ~a_wr; b_wr = ~b_wr;
        a_wvalid = 1; b_wvalid = 1; ddr_ready = 1; ddr_rvalid = 1;
        #1;
        chk("gnt", {b_gnt, a_gnt}, (owner == 1) ? 64'd2 : 64'd1);
        chk("hit_early", ddr_hit_early, 64'd1);
        chk("hit_in_early", ddr_hit, 64'd0);
        chk("addr", ddr_addr, cfg_addr[owner]);
        chk("write", ddr_write, cfg_wr[owner]);
        chk("no_beat_early", {a_wready, b_wready, a_rvalid, b_rvalid, ddr_wvalid}, 64'd0);
    endtask

    // Beat-by-beat transfer against the burst rules, then DONE and the gap cycle.
    task automatic xfer_phase(input int owner, input int term_at, input bit easy, output int beats);
        logic        wr;
        int          len;
        bit          ended, rdy, wt, vld, trm, exp_beat;
        logic [63:0] rd;
        logic [7:0]  exp_cbe;
        wr = cfg_wr[owner];
        len = int'(cfg_len[owner]);
        ended = 0;
        beats = 0;
        for (int c = 0; c < 300 && !ended; c++) begin
            @(negedge clk);
            rdy = easy ? 1'b1 : ($urandom_range(0, 3) != 0);
            wt  = easy ? 1'b0 : ($urandom_range(0, 4) == 0);
            vld = easy ? 1'b1 : ($urandom_range(0, 3) != 0);
            trm = (term_at >= 0) && (beats == term_at);
            rd  = {$urandom, $urandom};
            ddr_ready = rdy; ddr_wait = wt; ddr_term = trm; ddr_rdata = rd;
            ddr_rvalid = !wr && vld;
            ddr_not_ready = easy ? 1'b0 : 1'($urandom_range(0, 1));
            a_wvalid = (owner == 0) ? (wr && vld) : 1'($urandom_range(0, 1));
            a_wdata  = (owner == 0) ? m_wdata[beats] : {$urandom, $urandom};
            a_be     = (owner == 0) ? m_be[beats] : 8'($urandom);
            b_wvalid = (owner == 1) ? (wr && vld) : 1'($urandom_range(0, 1));
            b_wdata  = (owner == 1) ? m_wdata[beats] : {$urandom, $urandom};
            b_be     = (owner == 1) ? m_be[beats] : 8'($urandom);
            #1;
            exp_beat = wr ? (vld && rdy && !wt) : vld;
            chk("hit", ddr_hit, 64'd1);
            chk("done_in_xfer", ddr_done, 64'd0);
            chk("err_in_xfer", err, 64'd0);
            chk("own_wready", (owner == 1) ? b_wready : a_wready, wr && rdy && !wt);
            chk("other_wready", (owner == 1) ? a_wready : b_wready, 64'd0);
            chk("ddr_wvalid", ddr_wvalid, wr && exp_beat);
            if (wr && exp_beat) begin
                exp_cbe = ~m_be[beats];
                chk("wdata", ddr_wdata, m_wdata[beats]);
                chk("cbe", ddr_cbe, exp_cbe);
            end
            chk("own_rvalid", (owner == 1) ? b_rvalid : a_rvalid, !wr && vld);
            chk("other_rvalid", (owner == 1) ? a_rvalid : b_rvalid, 64'd0);
            if (!wr && vld) chk("rdata", (owner == 1) ? b_rdata : a_rdata, rd);
            if (exp_beat) beats++;
            ended = trm || (exp_beat && beats == len + 1);
        end
        chk("burst_end", ended, 64'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("ddr_done", ddr_done, 64'd1);
        chk("own_done", {b_done, a_done}, (owner == 1) ? 64'd2 : 64'd1);
        chk("hit_off", ddr_hit, 64'd0);
        chk("addr_hold", ddr_addr, cfg_addr[owner]);
        m_last = owner;
        @(negedge clk);
        #1;
        chk("gap", {ddr_done, a_done, b_done, a_gnt, b_gnt}, 64'd0);
    endtask

    initial begin
        int own, beats, term_at;
        logic [1:0] reqs;
        a_wr = 0; a_addr = '0; a_len = '0; b_wr = 0; b_addr = '0; b_len = '0;
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        zero_check("reset");
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Contested single-beat bursts alternate A,B,A,B from reset.
        for (int i = 0; i < 4; i++) begin
            randomize_cfg();
            cfg_len[0] = 0; cfg_len[1] = 0;
            grant_phase(2'b11, own);
            xfer_phase(own, -1, 1'b1, beats);
            chk("rr_beats", beats, 64'd1);
        end

        randomize_cfg();
        cfg_wr[0] = 1; cfg_len[0] = 3;
        grant_phase(2'b01, own);
        xfer_phase(own, -1, 1'b1, beats);
        chk("a_write_beats", beats, 64'd4);

        randomize_cfg();
        cfg_wr[1] = 0; cfg_len[1] = 7;
        grant_phase(2'b10, own);
        xfer_phase(own, -1, 1'b0, beats);
        chk("b_read_beats", beats, 64'd8);

        randomize_cfg();
        cfg_wr[0] = 1; cfg_len[0] = 7;
        grant_phase(2'b01, own);
        xfer_phase(own, 2, 1'b1, beats);
        chk("term_beats", beats, 64'd3);

        @(negedge clk);
        ddr_not_ready = 1; a_req = 1; b_req = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("not_ready_gnt", {a_gnt, b_gnt, ddr_hit_early}, 64'd0);
        end
        idle_inputs();
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            randomize_cfg();
            reqs = 2'($urandom_range(1, 3));
            grant_phase(reqs, own);
            term_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cfg_len[own])) : -1;
            xfer_phase(own, term_at, 1'b0, beats);
            if (term_at < 0) chk("rand_beats", beats, cfg_len[own] + 1);
        end

        // Stalled write: timeout ends it when enabled, otherwise it hangs.
        randomize_cfg();
        cfg_wr[0] = 1; cfg_len[0] = 3;
        grant_phase(2'b01, own);
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            ddr_ready = 0; a_wvalid = 1; a_wdata = m_wdata[0]; a_be = m_be[0];
            #1;
            chk("stall_done", ddr_done, 64'd0);
            chk("stall_err", err, 64'd0);
            chk("stall_wvalid", ddr_wvalid, 64'd0);
        end
        @(negedge clk);
        #1;
`ifdef DDR_REQ_ARB_TIMEOUT_EN
        chk("timeout_err", err, 64'd1);
        chk("timeout_done", {ddr_done, a_done}, 64'd3);
        m_last = 0;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("err_pulse", err, 64'd0);
        grant_phase(2'b01, own);
        @(negedge clk);
        ddr_ready = 1; a_wvalid = 1; a_wdata = m_wdata[0]; a_be = m_be[0];
        #1;
        chk("pre_reset_beat", ddr_wvalid, 64'd1);
`else
        chk("hang_err", err, 64'd0);
        chk("hang_done", ddr_done, 64'd0);
        chk("hang_hit", ddr_hit, 64'd1);
        ddr_ready = 1;
        #1;
        chk("pre_reset_beat", ddr_wvalid, 64'd1);
`endif
        b_wvalid = 1; ddr_rvalid = 1; ddr_rdata = {$urandom, $urandom};
        rst_n = 0;
        #1;
        zero_check("mid_reset");
        m_last = 1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("no_done_after_reset", {ddr_done, a_done, b_done, ddr_hit}, 64'd0);
        end

        randomize_cfg();
        cfg_wr[0] = 0; cfg_len[0] = 2;
        grant_phase(2'b01, own);
        xfer_phase(own, -1, 1'b0, beats);
        chk("post_reset_beats", beats, 64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
